// File: rtl/multdiv_issue_pkg.sv
// Shared types and defaults for the mult/div issue block.
// Holds the FSM state encoding, exception codes and status index.
package multdiv_issue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } md_state_e;

  localparam int STATUS_REG_DEF = 30;
  localparam int MULT_EXC_DEF   = 4;
  localparam int DIV_EXC_DEF    = 5;
  localparam int TIMEOUT_DEF    = 64;

  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/md_wait_counter.sv
// Wait-cycle counter for the mult/div issue FSM.
// Ports: clock, reset, clear, en -> count, tc (count == TIMEOUT-1).
module md_wait_counter
  import multdiv_issue_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CW      = cnt_width(TIMEOUT)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_issue.sv
// Issues one mult/div op to the unit, stalls until done, writes back.
// Ports: exec-stage start/flush/operands/rd, unit ctrl/operands/result, stall, wb_*, busy.
module multdiv_issue
  import multdiv_issue_pkg::*;
#(
  parameter int STATUS_REG    = STATUS_REG_DEF,
  parameter int MULT_EXC_CODE = MULT_EXC_DEF,
  parameter int DIV_EXC_CODE  = DIV_EXC_DEF,
  parameter int TIMEOUT       = TIMEOUT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic        flush,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic [4:0]  rd,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        busy
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [4:0]  STATUS_W = 5'(STATUS_REG);
  localparam logic [31:0] MULT_W   = 32'(MULT_EXC_CODE);
  localparam logic [31:0] DIV_W    = 32'(DIV_EXC_CODE);

  md_state_e     state;
  logic          is_mult_q;
  logic [4:0]    rd_q;
  logic          wb_en_q;
  logic [CW-1:0] count;
  logic          tc;
  logic          go;
  logic          rdy_ok;
  logic          finish;
  logic          exc;

  assign go = start_mult | start_div;

  // First WAIT cycle may still see the previous op's ready flag.
  assign rdy_ok = md_resultRDY && (count != '0);
  assign finish = rdy_ok || tc;
  assign exc    = rdy_ok ? md_exception : 1'b1;

  md_wait_counter #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_cnt (
    .clock (clock),
    .reset (reset),
    .clear (state != ST_WAIT),
    .en    (state == ST_WAIT),
    .count (count),
    .tc    (tc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      is_mult_q   <= 1'b0;
      rd_q        <= '0;
      md_operandA <= '0;
      md_operandB <= '0;
      wb_en_q     <= 1'b0;
      wb_reg      <= '0;
      wb_data     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (go && !flush) begin
            md_operandA <= operandA;
            md_operandB <= operandB;
            rd_q        <= rd;
            is_mult_q   <= start_mult;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= flush ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (finish) begin
            state <= ST_DONE;
            if (exc) begin
              wb_reg  <= STATUS_W;
              wb_data <= is_mult_q ? MULT_W : DIV_W;
              wb_en_q <= 1'b1;
            end else begin
              wb_reg  <= rd_q;
              wb_data <= md_result;
              wb_en_q <= (rd_q != '0);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ctrl_MULT = (state == ST_ISSUE) && is_mult_q;
  assign ctrl_DIV  = (state == ST_ISSUE) && !is_mult_q;
  assign busy      = (state != ST_IDLE);
  assign wb_valid  = (state == ST_DONE) && wb_en_q && !flush;
  assign stall     = ((state == ST_IDLE) && go)
                   || (state == ST_ISSUE)
                   || (state == ST_WAIT);

endmodule

// File: tb/tb_multdiv_issue.sv
// Randomized and directed bench for multdiv_issue.
// Transaction-level timing model drives the unit and checks every cycle.
module tb_multdiv_issue;

  localparam int TO = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic        flush;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic [4:0]  rd;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  multdiv_issue dut (
    .clock        (clock),
    .reset        (reset),
    .start_mult   (start_mult),
    .start_div    (start_div),
    .flush        (flush),
    .operandA     (operandA),
    .operandB     (operandB),
    .rd           (rd),
    .ctrl_MULT    (ctrl_MULT),
    .ctrl_DIV     (ctrl_DIV),
    .md_operandA  (md_operandA),
    .md_operandB  (md_operandB),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_resultRDY (md_resultRDY),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic expect_eq(input string tag,
                           input logic [63:0] got,
                           input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic idle_inputs();
    start_mult   = 1'b0;
    start_div    = 1'b0;
    flush        = 1'b0;
    operandA     = '0;
    operandB     = '0;
    rd           = '0;
    md_result    = '0;
    md_exception = 1'b0;
    md_resultRDY = 1'b0;
  endtask

  // k: WAIT count at which the unit answers (>= TO means never).
  // fc: cycle (0 = start cycle) at which flush pulses (large = none).
  task automatic run_op(input bit sm, input bit sd,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input int k,
                        input logic [31:0] res, input bit exc,
                        input bit stale, input int fc);
    bit          mult;
    bit          answered;
    bit          exc_eff;
    bit          hit;
    bit          wb_exp;
    int          rdy_c;
    int          done_c;
    int          end_c;
    logic [4:0]  wreg;
    logic [31:0] wdat;
    logic [1:0]  ctrl_exp;
    mult     = sm;
    answered = (k >= 1) && (k <= TO - 1);
    rdy_c    = 2 + k;
    done_c   = answered ? 3 + k : 2 + TO;
    exc_eff  = answered ? exc : 1'b1;
    hit      = (fc <= done_c);
    end_c    = hit ? fc : done_c;
    wb_exp   = !hit && (exc_eff || (r != 0));
    wreg     = exc_eff ? 5'd30 : r;
    wdat     = exc_eff ? (mult ? 32'd4 : 32'd5) : res;
    for (int c = 0; c <= end_c + 2; c++) begin
      @(negedge clock);
      start_mult   = (c == 0) && sm;
      start_div    = (c == 0) && sd;
      operandA     = (c == 0) ? a : $urandom;
      operandB     = (c == 0) ? b : $urandom;
      rd           = (c == 0) ? r : 5'($urandom);
      flush        = (c == fc);
      md_resultRDY = (c == rdy_c) || (stale && (c == 1 || c == 2));
      md_result    = (c == rdy_c) ? res : (32'hBAD0_0000 | $urandom_range(0, 255));
      md_exception = (c == rdy_c) ? exc : stale;
      #1;
      ctrl_exp = (c == 1 && fc != 0) ? (mult ? 2'b10 : 2'b01) : 2'b00;
      expect_eq("ctrl", {ctrl_MULT, ctrl_DIV}, ctrl_exp);
      expect_eq("stall", stall, (c <= end_c) && (c < done_c));
      expect_eq("busy", busy, (c >= 1) && (c <= end_c));
      expect_eq("wb_valid", wb_valid, wb_exp && (c == done_c));
      if (fc != 0 && (c == 1 || c == end_c)) begin
        expect_eq("opA", md_operandA, a);
        expect_eq("opB", md_operandB, b);
      end
      if (wb_exp && c == done_c) begin
        expect_eq("wb_reg", wb_reg, wreg);
        expect_eq("wb_data", wb_data, wdat);
      end
    end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic check_all_zero(input string tag);
    expect_eq(tag, {ctrl_MULT, ctrl_DIV, stall, wb_valid, busy,
                    wb_reg, 27'd0}, 64'd0);
    expect_eq(tag, {md_operandA, md_operandB}, 64'd0);
    expect_eq(tag, wb_data, 64'd0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check_all_zero("reset");

    run_op(1, 0, 32'd7, 32'd6, 5'd5, 16, 32'd42, 0, 0, 999);
    run_op(0, 1, 32'd10, 32'd0, 5'd9, 3, 32'd0, 1, 0, 999);
    run_op(1, 0, 32'd3, 32'd4, 5'd7, 3, 32'hDEAD, 0, 1, 999);
    run_op(1, 0, 32'd8, 32'd9, 5'd3, 1000, 32'd72, 0, 0, 999);
    run_op(1, 0, 32'd2, 32'd2, 5'd4, 20, 32'd4, 0, 0, 7);
    run_op(1, 1, 32'd5, 32'd5, 5'd6, 2, 32'd25, 0, 0, 999);
    run_op(1, 0, 32'd2, 32'd3, 5'd0, 2, 32'd6, 0, 0, 999);
    run_op(0, 1, 32'd99, 32'd3, 5'd8, TO - 1, 32'd33, 0, 0, 999);
    run_op(0, 1, 32'd12, 32'd4, 5'd8, 1, 32'd3, 0, 0, 999);
    run_op(1, 0, 32'd1, 32'd1, 5'd2, 4, 32'd1, 0, 0, 7);
    run_op(1, 0, 32'd1, 32'd1, 5'd2, 4, 32'd1, 0, 0, 0);
    run_op(0, 1, 32'd6, 32'd2, 5'd2, 4, 32'd3, 0, 0, 1);

    // Reset while waiting abandons the op.
    @(negedge clock);
    start_mult = 1'b1;
    operandA   = 32'h1234;
    operandB   = 32'h5678;
    rd         = 5'd11;
    @(negedge clock);
    idle_inputs();
    repeat (6) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_all_zero("rst_wait");
    repeat (3) @(negedge clock);
    #1;
    expect_eq("rst_quiet", {busy, wb_valid, stall}, 3'b000);

    for (int i = 0; i < 40; i++) begin
      bit          sm;
      bit          sd;
      bit          ex;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          k;
      int          fc;
      sm = $urandom_range(0, 1);
      sd = !sm || ($urandom_range(0, 3) == 0);
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      k  = ($urandom_range(0, 5) == 0) ? $urandom_range(60, 70)
                                       : $urandom_range(1, 20);
      fc = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 20) : 999;
      if (sm) begin
        res = a * b;
        ex  = ($urandom_range(0, 5) == 0);
      end else begin
        res = (b == 0) ? 32'd0 : a / b;
        ex  = (b == 0);
      end
      run_op(sm, sd, a, b, 5'($urandom), k, res, ex,
             bit'($urandom_range(0, 1)), fc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multdiv_issue.md
Name: multdiv_issue

Overview:
- Processor-side initiator for the multiply/divide unit.
- Accepts a decoded mult/div op from the execute stage and drives the unit's ctrl_MULT/ctrl_DIV start pulse and operands.
- Stalls the pipeline until the unit reports ready, then produces one writeback: either the result to rd, or the exception status code to the status register.
- Sits between the execute stage and the multdiv unit.

Parameters:
- STATUS_REG, 30: register index written on exception.
- MULT_EXC_CODE, 4: status value written on mult exception.
- DIV_EXC_CODE, 5: status value written on div exception.
- TIMEOUT, 64: max WAIT cycles before forced exception completion.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start_mult  input  1  execute stage requests a multiply this cycle.
- start_div  input  1  execute stage requests a divide this cycle.
- flush  input  1  abort the in-flight op; no writeback.
- operandA  input  32  first source value.
- operandB  input  32  second source value.
- rd  input  5  destination register.
- ctrl_MULT  output  1  one-cycle start pulse to the unit.
- ctrl_DIV  output  1  one-cycle start pulse to the unit.
- md_operandA  output  32  latched operand A to the unit.
- md_operandB  output  32  latched operand B to the unit.
- md_result  input  32  unit result.
- md_exception  input  1  unit exception flag.
- md_resultRDY  input  1  unit ready flag.
- stall  output  1  freeze upstream pipeline.
- wb_valid  output  1  one-cycle writeback strobe.
- wb_reg  output  5  writeback register index.
- wb_data  output  32  writeback value.
- busy  output  1  op in flight (state not IDLE).

Behaviour:
- Reset (synchronous, active-high): state=IDLE, counter=0. All outputs 0, including latched operands, rd and op type. Reset mid-operation abandons the op with no writeback.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On start_mult or start_div, latch operandA, operandB, rd and op type (mult=1), then go to ISSUE.
  - If start_mult and start_div are both high, mult wins.
- ISSUE (exactly 1 cycle):
  - ctrl_MULT or ctrl_DIV = 1 per the latched op type, never both.
  - md_operandA/B already hold the latched values and stay constant until the next IDLE capture.
  - Go to WAIT; counter=0.
- WAIT:
  - counter increments each cycle.
  - md_resultRDY is ignored while counter==0, since it may be stale from the prior op.
  - When md_resultRDY=1 and counter>=1: capture md_result and md_exception, go to DONE.
  - When counter reaches TIMEOUT-1 without RDY: capture exception=1, go to DONE.
- DONE (1 cycle): wb_valid=1, then go to IDLE.
  - Exception set: wb_reg=STATUS_REG, wb_data = MULT_EXC_CODE if mult, else DIV_EXC_CODE, zero-extended.
  - Otherwise: wb_reg=latched rd, wb_data=captured result.
  - wb_valid is suppressed (0) when there is no exception and rd==0.
  - wb_reg/wb_data hold their values after DONE; they are only meaningful while wb_valid=1.
- stall, combinational: 1 when (IDLE and (start_mult|start_div)), or state is ISSUE or WAIT. It is 0 in DONE, so upstream advances in the same cycle wb_valid pulses.
- busy = (state != IDLE).
- start_* while busy is ignored; upstream is stalled, so this only occurs on an upstream fault.
- flush: in ISSUE/WAIT/DONE, go to IDLE next cycle with wb_valid=0. If flush coincides with DONE, wb_valid is forced 0 that cycle. In IDLE, flush blocks a simultaneous start.
- Latency: start cycle T → ctrl pulse at T+1 → earliest wb_valid at T+4 (RDY seen at T+3).

Decomposition:
- Shared package: state encoding (2-bit IDLE/ISSUE/WAIT/DONE), default exception codes, STATUS_REG default.
- Sub-module: md_wait_counter, a resettable up-counter with terminal-count flag at TIMEOUT-1 and a clear input. The FSM, latches and writeback mux stay in the top module.

Test Plan:
- Mult, no exception: start_mult, A=7, B=6, rd=5; unit returns RDY with result 42 at the 17th WAIT cycle → ctrl_MULT high exactly one cycle; stall high T..WAIT end; one wb_valid with wb_reg=5, wb_data=42.
- Div by zero: start_div, A=10, B=0, rd=9; unit returns RDY with exception=1 → wb_reg=30, wb_data=5, no write to r9.
- Stale RDY: md_resultRDY held high through ISSUE and the first WAIT cycle; the real result 0xDEAD arrives at WAIT counter 3 → captured value is 0xDEAD, not the earlier data.
- Timeout: mult issued, RDY never asserted → wb_valid at cycle T+1+1+TIMEOUT with wb_reg=30, wb_data=4.
- Flush and reset: flush at WAIT counter 5 → IDLE next cycle, no wb_valid, stall drops. Reset asserted in WAIT → all outputs 0 next cycle.
- Simultaneous start and rd=0: start_mult and start_div together → only ctrl_MULT pulses. A separate mult with rd=0 and no exception → wb_valid stays 0.
